// File: rtl/nexys_starship_spawn_gen.sv
// nexys_starship_spawn_gen: a shared Galois LFSR drives NUM_CH spawn channels.
// Each channel takes its own rotated window of the LFSR and compares it with its
// threshold. On a hit the channel raises Spawn and holds it until Ack arrives,
// then stays locked out for Cooldown enabled cycles. Spawn_count is a saturating
// count of the acknowledged spawns.
module nexys_starship_spawn_gen #(
  parameter int                NUM_CH    = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_INIT = 16'hACE1,
  parameter int                THR_W     = 8,
  parameter int                CD_W      = 8,
  parameter int                CNT_W     = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    En,
  input  logic                    Seed_load,
  input  logic [LFSR_W-1:0]       Seed,
  input  logic [NUM_CH*THR_W-1:0] Threshold,
  input  logic [CD_W-1:0]         Cooldown,
  input  logic [NUM_CH-1:0]       Ack,
  output logic [NUM_CH-1:0]       Spawn,
  output logic [CNT_W-1:0]        Spawn_count
);

  typedef enum logic [1:0] {IDLE, ARMED, COOL} ch_state_t;

  localparam int IDX_W = $clog2(LFSR_W);
  localparam int NW    = $clog2(NUM_CH + 1);
  localparam int SUM_W = CNT_W + NW;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];
  logic [CD_W-1:0]   cd_q    [NUM_CH];
  logic [CD_W-1:0]   cd_d    [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] spawn_d;
  logic [NUM_CH-1:0] accepted;
  logic [NW-1:0]     n_acc;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  count_d;

  // Low THR_W bits of v rotated left by rot.
  function automatic logic [THR_W-1:0] window(input logic [LFSR_W-1:0] v, input int rot);
    logic [THR_W-1:0] s;
    for (int j = 0; j < THR_W; j++)
      s[j] = v[IDX_W'((j - rot + LFSR_W) % LFSR_W)];
    return s;
  endfunction

  // State register: LFSR, channel states, cooldown counters, Spawn and count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q      <= SEED_INIT;
      Spawn       <= '0;
      Spawn_count <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cd_q[i]    <= '0;
      end
    end else begin
      lfsr_q      <= lfsr_d;
      Spawn       <= spawn_d;
      Spawn_count <= count_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cd_q[i]    <= cd_d[i];
      end
    end
  end

  // LFSR next value: reseed has priority, a zero seed is forced to 1 to avoid lockup.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (Seed_load)
      lfsr_d = (Seed == '0) ? LFSR_W'(1) : Seed;
    else if (En)
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  // Per-channel hit detection on the current (pre-step) LFSR value.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++)
      hit[i] = En && (window(lfsr_q, (3 * i) % LFSR_W) < Threshold[i*THR_W +: THR_W]);
  end

  // Channel next-state logic: IDLE -> ARMED on hit, ARMED -> COOL/IDLE on Ack,
  // COOL counts enabled cycles back to IDLE.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cd_d[i]    = cd_q[i];
      if (Seed_load) begin
        state_d[i] = IDLE;
        cd_d[i]    = '0;
      end else begin
        unique case (state_q[i])
          IDLE:  if (hit[i]) state_d[i] = ARMED;
          ARMED: if (Ack[i]) begin
            state_d[i] = (Cooldown == '0) ? IDLE : COOL;
            cd_d[i]    = Cooldown;
          end
          COOL:  if (En) begin
            if (cd_q[i] == CD_W'(1)) begin
              state_d[i] = IDLE;
              cd_d[i]    = '0;
            end else begin
              cd_d[i] = cd_q[i] - CD_W'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            cd_d[i]    = '0;
          end
        endcase
      end
    end
  end

  // Outputs: Spawn follows the ARMED state; count adds accepted Acks and saturates.
  always_comb begin
    spawn_d  = '0;
    accepted = '0;
    n_acc    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      spawn_d[i]  = (state_d[i] == ARMED);
      accepted[i] = !Seed_load && (state_q[i] == ARMED) && Ack[i];
      n_acc       = n_acc + NW'(accepted[i]);
    end
    sum     = {{NW{1'b0}}, Spawn_count} + SUM_W'(n_acc);
    count_d = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_nexys_starship_spawn_gen.sv
// Testbench for nexys_starship_spawn_gen: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural model of the channels.
module tb_nexys_starship_spawn_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        En;
  logic        Seed_load;
  logic [15:0] Seed;
  logic [63:0] Threshold;
  logic [7:0]  Cooldown;
  logic [7:0]  Ack;
  logic [7:0]  Spawn;
  logic [7:0]  Spawn_count;

  int tests = 0;
  int fails = 0;

  // Behavioural model: armed flag, remaining cooldown, event count, LFSR value.
  logic [7:0]  m_armed;
  int          m_cool [8];
  int          m_cnt;
  int unsigned m_lfsr;

  nexys_starship_spawn_gen dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .En         (En),
    .Seed_load  (Seed_load),
    .Seed       (Seed),
    .Threshold  (Threshold),
    .Cooldown   (Cooldown),
    .Ack        (Ack),
    .Spawn      (Spawn),
    .Spawn_count(Spawn_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rotl16(input int unsigned x, input int r);
    return ((x << r) | (x >> (16 - r))) & 32'hFFFF;
  endfunction

  task automatic model_reset();
    m_lfsr  = 32'hACE1;
    m_armed = '0;
    m_cnt   = 0;
    for (int c = 0; c < 8; c++) m_cool[c] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int acc = 0;
    if (Seed_load) begin
      m_lfsr  = (Seed == 16'h0) ? 1 : Seed;
      m_armed = '0;
      for (int c = 0; c < 8; c++) m_cool[c] = 0;
      return;
    end
    for (int c = 0; c < 8; c++) begin
      int unsigned sample = rotl16(m_lfsr, (3 * c) % 16) & 32'hFF;
      if (m_armed[c]) begin
        if (Ack[c]) begin
          acc++;
          m_armed[c] = 1'b0;
          m_cool[c]  = Cooldown;
        end
      end else if (m_cool[c] > 0) begin
        if (En) m_cool[c]--;
      end else if (En && sample < Threshold[c*8 +: 8]) begin
        m_armed[c] = 1'b1;
      end
    end
    m_cnt = (m_cnt + acc > 255) ? 255 : m_cnt + acc;
    if (En) m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr & 1) != 0 ? 32'hB400 : 0);
  endtask

  // One clock: update the model, wait for the edge, compare just after it.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check("spawn", Spawn, m_armed);
    check("count", Spawn_count, m_cnt);
    check("lfsr", dut.lfsr_q, m_lfsr);
  endtask

  initial begin
    int unsigned saved;
    int          n;
    Reset = 1'b1; En = 1'b0; Seed_load = 1'b0; Seed = '0;
    Threshold = '0; Cooldown = '0; Ack = '0;
    model_reset();
    #3;
    check("rst_spawn", Spawn, 0);
    check("rst_count", Spawn_count, 0);
    check("rst_lfsr", dut.lfsr_q, 16'hACE1);
    #9 Reset = 1'b0;

    // LFSR sequence from seed 1.
    Seed_load = 1'b1; Seed = 16'h0001; tick();
    Seed_load = 1'b0; En = 1'b1;
    tick(); check("lfsr_seq0", dut.lfsr_q, 16'hB400);
    tick(); check("lfsr_seq1", dut.lfsr_q, 16'h5A00);
    tick(); check("lfsr_seq2", dut.lfsr_q, 16'h2D00);
    tick(); check("lfsr_seq3", dut.lfsr_q, 16'h1680);

    // Zero seed forced to 1, no lockup.
    Seed_load = 1'b1; Seed = 16'h0000; En = 1'b0; tick();
    check("zero_seed", dut.lfsr_q, 16'h0001);
    Seed_load = 1'b0; En = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    check("no_lockup", (dut.lfsr_q != 16'h0), 1);

    // Channel 0 spawn / Ack / cooldown of 3.
    Threshold[7:0] = 8'hFF; Cooldown = 8'd3;
    n = 0;
    while (!Spawn[0] && n < 50) begin tick(); n++; end
    check("spawn0_rise", Spawn[0], 1);
    tick(); tick();
    Ack = 8'h01; tick(); Ack = 8'h00;
    check("spawn0_fall", Spawn[0], 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("spawn0_cool", Spawn[0], 0);
    end
    check("count_one", Spawn_count, 1);

    // Channel 2 holds through En=0 and still clears on Ack.
    Threshold = '0; Threshold[23:16] = 8'hFF; Cooldown = 8'd0;
    for (int k = 0; k < 8; k++) tick();
    n = 0;
    while (!Spawn[2] && n < 50) begin tick(); n++; end
    check("spawn2_rise", Spawn[2], 1);
    En = 1'b0; saved = m_lfsr;
    for (int k = 0; k < 10; k++) tick();
    check("spawn2_hold", Spawn[2], 1);
    check("lfsr_hold", dut.lfsr_q, saved);
    Ack = 8'h04; tick(); Ack = 8'h00;
    check("spawn2_ack", Spawn[2], 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if (k % 32 == 0) begin
        Threshold = {$urandom, $urandom};
        Cooldown  = 8'($urandom_range(0, 5));
      end
      En        = ($urandom_range(0, 3) != 0);
      Ack       = 8'($urandom);
      Seed_load = ($urandom_range(0, 39) == 0);
      Seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
    end
    Seed_load = 1'b0;

    // All channels, Ack held, no cooldown: toggling and saturation.
    Threshold = {8{8'hFF}}; Ack = 8'hFF; Cooldown = 8'd0; En = 1'b1;
    for (int k = 0; k < 150; k++) tick();
    check("count_sat", Spawn_count, 255);
    tick();
    check("count_sat_hold", Spawn_count, 255);

    // Reset mid-COOL with count 5.
    Ack = '0; Threshold = '0;
    Reset = 1'b1; model_reset(); #2 Reset = 1'b0;
    Threshold[7:0] = 8'hFF; Ack = 8'h01;
    n = 0;
    while (m_cnt < 4 && n < 100) begin tick(); n++; end
    Ack = 8'h00; Cooldown = 8'd50;
    n = 0;
    while (!m_armed[0] && n < 50) begin tick(); n++; end
    Ack = 8'h01; tick(); Ack = 8'h00;
    tick(); tick();
    check("count_five", Spawn_count, 5);
    #2 Reset = 1'b1; model_reset();
    #1;
    check("async_spawn", Spawn, 0);
    check("async_count", Spawn_count, 0);
    check("async_lfsr", dut.lfsr_q, 16'hACE1);
    #1 Reset = 1'b0;
    Threshold = '0;
    for (int k = 0; k < 3; k++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nexys_starship_spawn_gen.md
NEXYS_STARSHIP_SPAWN_GEN -- requirements
Module: nexys_starship_spawn_gen

Interface
- REQ-001: Parameter NUM_CH, default 8: number of independent spawn channels, range 1..16.
- REQ-002: Parameter LFSR_W, default 16: LFSR width, range 8..32.
- REQ-003: Parameter TAPS, default 16'hB400: Galois feedback mask, LFSR_W bits.
- REQ-004: Parameter SEED_INIT, default 16'hACE1: LFSR reset value; must be nonzero.
- REQ-005: Parameter THR_W, default 8: sample/threshold width; must be <= LFSR_W.
- REQ-006: Parameter CD_W, default 8: cooldown counter width.
- REQ-007: Parameter CNT_W, default 8: spawn event counter width.
- REQ-008: Clk  input  1  system clock; all state changes on rising edge.
- REQ-009: Reset  input  1  asynchronous, active-high reset.
- REQ-010: En  input  1  advance enable for the LFSR and cooldown counters.
- REQ-011: Seed_load  input  1  synchronous LFSR reseed strobe.
- REQ-012: Seed  input  LFSR_W  reseed value.
- REQ-013: Threshold  input  NUM_CH*THR_W  per-channel spawn threshold; channel i at [i*THR_W +: THR_W].
- REQ-014: Cooldown  input  CD_W  post-acknowledge lockout length in enabled cycles, shared by all channels.
- REQ-015: Ack  input  NUM_CH  per-channel spawn acknowledge.
- REQ-016: Spawn  output  NUM_CH  per-channel spawn request, registered.
- REQ-017: Spawn_count  output  CNT_W  saturating count of accepted spawns.

Function
- REQ-018: One Galois LFSR SHALL step when En=1: next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0); it SHALL hold when En=0.
- REQ-019: Channel i sample SHALL be the low THR_W bits of the current LFSR rotated left by (3*i) mod LFSR_W.
- REQ-020: Channel i hit SHALL be En=1 AND sample_i < Threshold_i (unsigned); Threshold_i=0 never hits.
- REQ-021: Each channel SHALL implement states IDLE, ARMED and COOL; Spawn[i]=1 only in ARMED.
- REQ-022: IDLE -> ARMED on hit; Spawn[i] SHALL rise on the clock edge that samples the hit (one-cycle latency).
- REQ-023: ARMED SHALL hold Spawn[i]=1 regardless of En or further hits until Ack[i]=1.
- REQ-024: ARMED with Ack[i]=1: go to COOL with cooldown counter = Cooldown, or to IDLE if Cooldown=0; Spawn[i] SHALL fall on that edge.
- REQ-025: COOL SHALL decrement its counter each En=1 cycle; when the counter is 1 and En=1, go to IDLE; hits SHALL be ignored in COOL.
- REQ-026: Ack[i] in IDLE or COOL SHALL be ignored.
- REQ-027: Spawn_count SHALL add the number of channels acknowledged in ARMED that cycle (0..NUM_CH), saturating at 2^CNT_W-1.
- REQ-028: Seed_load=1 SHALL have priority over En: LFSR <= Seed, or 1 if Seed=0; all channels -> IDLE; Spawn <= 0; counters cleared; Spawn_count unchanged.
- REQ-029: Channels SHALL be fully independent; simultaneous hits and Acks on any subset SHALL be handled in the same cycle.

Reset
- REQ-030: Reset=1 SHALL immediately set LFSR=SEED_INIT, all channels IDLE, Spawn=0, cooldown counters=0 and Spawn_count=0, including mid-ARMED or mid-COOL.
- REQ-031: The first hit evaluation after release SHALL use the SEED_INIT sample on the first edge with En=1.

Verification
- REQ-032: Seed_load with Seed=0x0001, then En=1 for 4 cycles -> LFSR 0xB400, 0x5A00, 0x2D00, 0x1680.
- REQ-033: Seed_load with Seed=0 -> LFSR=0x0001 next cycle; no lockup after 100 enabled cycles.
- REQ-034: Threshold_0=0xFF, Cooldown=3, Ack[0] pulsed 2 cycles after Spawn[0] rises -> Spawn[0] falls on the Ack edge, stays 0 for exactly 3 enabled cycles, then may re-assert; Spawn_count=1.
- REQ-035: All thresholds 0xFF, all Ack held high, Cooldown=0 -> all Spawn bits toggle every cycle; Spawn_count saturates at 255 and holds.
- REQ-036: Spawn[2]=1, En=0 for 10 cycles -> Spawn[2] held at 1; LFSR unchanged; Ack[2] still clears it.
- REQ-037: Reset asserted mid-COOL with Spawn_count=5 -> Spawn=0, Spawn_count=0, LFSR=0xACE1 without waiting for a clock edge.
